// File: rtl/uart_sample_bridge.sv
// uart_sample_bridge: assembles received UART bytes into samples for a FIR-style core, narrows
// each core result to a (optionally saturated) bit slice, buffers it in a small FIFO and
// serialises the buffered results back out through the UART transmitter handshake.
module uart_sample_bridge #(
    parameter int unsigned IN_BYTES   = 2,
    parameter int unsigned OUT_W      = 38,
    parameter int unsigned OUT_LSB    = 8,
    parameter int unsigned OUT_BYTES  = 2,
    parameter bit          BIG_ENDIAN = 1'b0,
    parameter bit          SAT        = 1'b0,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RX_TIMEOUT = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_ready,
    input  logic [7:0]                    rx_data,
    output logic [8*IN_BYTES-1:0]         fir_in,
    output logic                          fir_in_valid,
    input  logic [OUT_W-1:0]              fir_out,
    input  logic                          fir_out_valid,
    input  logic                          tx_busy,
    output logic                          tx_start,
    output logic [7:0]                    tx_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int unsigned IW   = 8 * IN_BYTES;
    localparam int unsigned SW   = 8 * OUT_BYTES;
    localparam int unsigned SMSB = OUT_LSB + SW - 1;
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = PW + 1;

    typedef enum logic [1:0] {StIdle, StSend, StHold, StWait} tx_state_e;

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    logic [2:0]    byte_cnt_q, byte_cnt_d;
    logic [IW-1:0] asm_q, asm_d;
    logic [31:0]   idle_q, idle_d;
    logic [IW-1:0] fir_in_q, fir_in_d;
    logic          fir_in_valid_q, fir_in_valid_d;
    logic [2:0]    rx_lane;
    logic [IW-1:0] asm_ins;

    assign rx_lane = BIG_ENDIAN ? (3'(IN_BYTES - 1) - byte_cnt_q) : byte_cnt_q;

    // Byte assembly, sample hand-off and partial-sample timeout.
    always_comb begin
        asm_ins = asm_q;
        for (int unsigned i = 0; i < IN_BYTES; i++) begin
            if (rx_lane == 3'(i)) begin
                asm_ins[8*i +: 8] = rx_data;
            end
        end
        byte_cnt_d     = byte_cnt_q;
        asm_d          = asm_q;
        idle_d         = '0;
        fir_in_d       = fir_in_q;
        fir_in_valid_d = 1'b0;
        if (rx_ready) begin
            // A byte arriving on the expiry cycle wins over the timeout.
            if (byte_cnt_q == 3'(IN_BYTES - 1)) begin
                fir_in_d       = asm_ins;
                fir_in_valid_d = 1'b1;
                byte_cnt_d     = '0;
                asm_d          = '0;
            end else begin
                asm_d      = asm_ins;
                byte_cnt_d = byte_cnt_q + 3'd1;
            end
        end else if ((RX_TIMEOUT != 0) && (byte_cnt_q != '0)) begin
            if (idle_q + 32'd1 >= RX_TIMEOUT) begin
                byte_cnt_d = '0;
                asm_d      = '0;
            end else begin
                idle_d = idle_q + 32'd1;
            end
        end
    end

    // Receive-side registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_q     <= '0;
            asm_q          <= '0;
            idle_q         <= '0;
            fir_in_q       <= '0;
            fir_in_valid_q <= 1'b0;
        end else begin
            byte_cnt_q     <= byte_cnt_d;
            asm_q          <= asm_d;
            idle_q         <= idle_d;
            fir_in_q       <= fir_in_d;
            fir_in_valid_q <= fir_in_valid_d;
        end
    end

    assign fir_in       = fir_in_q;
    assign fir_in_valid = fir_in_valid_q;

    // ------------------------------------------------------------------
    // Result slice with optional signed saturation
    // ------------------------------------------------------------------
    logic [SW-1:0]        slice;
    logic [OUT_W-1-SMSB:0] upper;
    logic                 unused_fir_out;

    assign upper          = fir_out[OUT_W-1:SMSB];
    // Bits below the slice are intentionally discarded.
    assign unused_fir_out = ^fir_out;

    // Clamp to signed max/min when the discarded upper bits are not a pure sign extension.
    always_comb begin
        slice = fir_out[SMSB:OUT_LSB];
        if (SAT && !((&upper) || !(|upper))) begin
            slice = fir_out[OUT_W-1] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [SW-1:0] mem_q [FIFO_DEPTH];
    logic [SW-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [SW-1:0] rd_data;

    assign fifo_full = (count_q == CW'(FIFO_DEPTH));
    // A full FIFO still accepts a write when the transmitter pops in the same cycle.
    assign push      = fir_out_valid && (!fifo_full || pop);
    assign rd_data   = mem_q[rd_ptr_q];

    // FIFO pointers, occupancy and sticky overflow flag.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            mem_d[wr_ptr_q] = slice;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (fir_out_valid && !push) begin
            overflow_d = 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage and control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign fifo_count = count_q;
    assign overflow   = overflow_q;

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    tx_state_e     state_q, state_d;
    logic [SW-1:0] shift_q, shift_d;
    logic [2:0]    idx_q, idx_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [2:0]    tx_lane;
    logic [2:0]    first_lane;

    assign tx_lane    = BIG_ENDIAN ? (3'(OUT_BYTES - 1) - idx_q) : idx_q;
    assign first_lane = BIG_ENDIAN ? 3'(OUT_BYTES - 1) : 3'd0;

    function automatic logic [7:0] pick_byte(input logic [SW-1:0] word, input logic [2:0] lane);
        logic [7:0] b;
        b = 8'h00;
        for (int unsigned i = 0; i < OUT_BYTES; i++) begin
            if (lane == 3'(i)) begin
                b = word[8*i +: 8];
            end
        end
        return b;
    endfunction

    // Next-state logic; all outputs are registered so tx_start is a clean one-cycle strobe.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = rd_data;
                    idx_d   = '0;
                    // Skip the SEND wait cycle when the transmitter is already free.
                    if (!tx_busy) begin
                        tx_data_d  = pick_byte(rd_data, first_lane);
                        tx_start_d = 1'b1;
                        state_d    = StHold;
                    end else begin
                        state_d = StSend;
                    end
                end
            end
            StSend: begin
                if (!tx_busy) begin
                    tx_data_d  = pick_byte(shift_q, tx_lane);
                    tx_start_d = 1'b1;
                    state_d    = StHold;
                end
            end
            StHold: begin
                state_d = StWait;
            end
            StWait: begin
                if (!tx_busy) begin
                    if (idx_q == 3'(OUT_BYTES - 1)) begin
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StSend;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Transmit FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            idx_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_sample_bridge.sv
// Scoreboard bench for uart_sample_bridge: a little-endian/truncating instance with the
// receive timeout enabled, and a big-endian/saturating instance, driven by the same stimulus.
module tb_uart_sample_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic [37:0] fir_out;
    logic        fir_out_valid;
    logic        hold_busy;

    logic        model_busy   [2];
    logic        tx_busy      [2];
    logic [15:0] fir_in       [2];
    logic        fir_in_valid [2];
    logic        tx_start     [2];
    logic [7:0]  tx_data      [2];
    logic [2:0]  fifo_count   [2];
    logic        overflow     [2];

    int errors = 0;
    int checks = 0;

    // Expected responses, index 0 = little-endian instance, 1 = big-endian instance.
    logic [15:0] fin_q0 [$];
    logic [15:0] fin_q1 [$];
    logic [7:0]  txb_q0 [$];
    logic [7:0]  txb_q1 [$];

    always #5 clk = ~clk;

    assign tx_busy[0] = model_busy[0] | hold_busy;
    assign tx_busy[1] = model_busy[1] | hold_busy;

    uart_sample_bridge #(
        .IN_BYTES(2), .OUT_W(38), .OUT_LSB(8), .OUT_BYTES(2), .BIG_ENDIAN(1'b0),
        .SAT(1'b0), .FIFO_DEPTH(4), .RX_TIMEOUT(1000)
    ) u_le (
        .clk(clk), .rst(rst), .rx_ready(rx_ready), .rx_data(rx_data),
        .fir_in(fir_in[0]), .fir_in_valid(fir_in_valid[0]),
        .fir_out(fir_out), .fir_out_valid(fir_out_valid),
        .tx_busy(tx_busy[0]), .tx_start(tx_start[0]), .tx_data(tx_data[0]),
        .fifo_count(fifo_count[0]), .overflow(overflow[0])
    );

    uart_sample_bridge #(
        .IN_BYTES(2), .OUT_W(38), .OUT_LSB(8), .OUT_BYTES(2), .BIG_ENDIAN(1'b1),
        .SAT(1'b1), .FIFO_DEPTH(4), .RX_TIMEOUT(0)
    ) u_be (
        .clk(clk), .rst(rst), .rx_ready(rx_ready), .rx_data(rx_data),
        .fir_in(fir_in[1]), .fir_in_valid(fir_in_valid[1]),
        .fir_out(fir_out), .fir_out_valid(fir_out_valid),
        .tx_busy(tx_busy[1]), .tx_start(tx_start[1]), .tx_data(tx_data[1]),
        .fifo_count(fifo_count[1]), .overflow(overflow[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h, want no output (t=%0t)", name, act, $time);
    endtask

    // Transmitter model: busy rises the cycle after tx_start and stays high for 4 cycles.
    task automatic busy_model(input int i);
        model_busy[i] = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start[i] === 1'b1) begin
                @(posedge clk);
                #1 model_busy[i] = 1'b1;
                repeat (4) @(posedge clk);
                #1 model_busy[i] = 1'b0;
            end
        end
    endtask

    initial busy_model(0);
    initial busy_model(1);

    task automatic mon_fir(input int i);
        logic [15:0] e;
        if ((i == 0 && fin_q0.size() == 0) || (i == 1 && fin_q1.size() == 0)) begin
            fail_unexpected($sformatf("fir_in[%0d] unexpected strobe", i), 32'(fir_in[i]));
        end else begin
            e = (i == 0) ? fin_q0.pop_front() : fin_q1.pop_front();
            check($sformatf("fir_in[%0d]", i), 32'(fir_in[i]), 32'(e));
        end
    endtask

    task automatic mon_tx(input int i);
        logic [7:0] e;
        check($sformatf("tx_start[%0d] while busy", i), 32'(tx_busy[i]), 32'd0);
        if ((i == 0 && txb_q0.size() == 0) || (i == 1 && txb_q1.size() == 0)) begin
            fail_unexpected($sformatf("tx_data[%0d] unexpected byte", i), 32'(tx_data[i]));
        end else begin
            e = (i == 0) ? txb_q0.pop_front() : txb_q1.pop_front();
            check($sformatf("tx_data[%0d]", i), 32'(tx_data[i]), 32'(e));
        end
    endtask

    // Monitor: pops and compares whenever an instance presents a strobe.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int i = 0; i < 2; i++) begin
                if (fir_in_valid[i] === 1'b1) mon_fir(i);
                if (tx_start[i] === 1'b1) mon_tx(i);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        rx_data = b;
        @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    // Strobe must appear in the cycle after the final byte and last exactly one cycle.
    task automatic check_strobe(input int i);
        @(negedge clk);
        check($sformatf("fir_in_valid[%0d] latency", i), 32'(fir_in_valid[i]), 32'd1);
        @(negedge clk);
        check($sformatf("fir_in_valid[%0d] width", i), 32'(fir_in_valid[i]), 32'd0);
    endtask

    task automatic issue(input logic [37:0] fo, input logic [15:0] le_s, input logic [15:0] be_s,
                         input bit accepted);
        @(posedge clk);
        #1 fir_out = fo;
        fir_out_valid = 1'b1;
        if (accepted) begin
            txb_q0.push_back(le_s[7:0]);
            txb_q0.push_back(le_s[15:8]);
            txb_q1.push_back(be_s[15:8]);
            txb_q1.push_back(be_s[7:0]);
        end
    endtask

    task automatic end_issue();
        @(posedge clk);
        #1 fir_out_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((txb_q0.size() != 0 || txb_q1.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (12) @(posedge clk);
        check("drain within budget", 32'(n < 3000), 32'd1);
        @(negedge clk);
        check("fifo_count[0] drained", 32'(fifo_count[0]), 32'd0);
        check("fifo_count[1] drained", 32'(fifo_count[1]), 32'd0);
    endtask

    task automatic check_reset_state();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst fir_in[%0d]", i), 32'(fir_in[i]), 32'd0);
            check($sformatf("rst fir_in_valid[%0d]", i), 32'(fir_in_valid[i]), 32'd0);
            check($sformatf("rst tx_start[%0d]", i), 32'(tx_start[i]), 32'd0);
            check($sformatf("rst tx_data[%0d]", i), 32'(tx_data[i]), 32'd0);
            check($sformatf("rst fifo_count[%0d]", i), 32'(fifo_count[i]), 32'd0);
            check($sformatf("rst overflow[%0d]", i), 32'(overflow[i]), 32'd0);
        end
    endtask

    // Watchdog: the run must always end by itself.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic [37:0] fo;
        logic [15:0] le_s;
        logic [15:0] be_s;
    } vec_t;

    vec_t        tx_vecs [5];
    logic [15:0] ov_s    [6];

    initial begin
        // fir_out, truncated slice (LE instance), saturated slice (BE instance)
        tx_vecs[0] = '{38'h00_0012_3456, 16'h1234, 16'h1234};
        tx_vecs[1] = '{38'h00_0100_0000, 16'h0000, 16'h7FFF};
        tx_vecs[2] = '{38'h3F_FF00_0000, 16'h0000, 16'h8000};
        tx_vecs[3] = '{38'h3F_FFFF_8000, 16'hFF80, 16'hFF80};
        tx_vecs[4] = '{38'h00_00AB_CD00, 16'hABCD, 16'h7FFF};
        ov_s[0] = 16'h1122; ov_s[1] = 16'h2233; ov_s[2] = 16'h3344;
        ov_s[3] = 16'h4455; ov_s[4] = 16'h5566; ov_s[5] = 16'h6677;

        rst = 1'b1;
        rx_ready = 1'b0;
        rx_data = 8'h00;
        fir_out = '0;
        fir_out_valid = 1'b0;
        hold_busy = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state();

        // Receive: 0x34 then 0x12.
        fin_q0.push_back(16'h1234);
        fin_q1.push_back(16'h3412);
        send_byte(8'h34);
        send_byte(8'h12);
        check_strobe(0);
        check(" fir_in[1] same cycle", 32'(fir_in[1]), 32'h3412);

        // Transmit and saturation vectors, one at a time.
        for (int k = 0; k < 5; k++) begin
            issue(tx_vecs[k].fo, tx_vecs[k].le_s, tx_vecs[k].be_s, 1'b1);
            end_issue();
            wait_drain();
        end
        check("overflow[0] before full", 32'(overflow[0]), 32'd0);

        // Overflow: transmitter held busy, six back-to-back results, the sixth is dropped.
        @(posedge clk);
        #1 hold_busy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            issue({14'h0, ov_s[k], 8'h00}, ov_s[k], ov_s[k], k < 5);
        end
        end_issue();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("fifo_count[%0d] full", i), 32'(fifo_count[i]), 32'd4);
            check($sformatf("overflow[%0d] set", i), 32'(overflow[i]), 32'd1);
        end
        @(posedge clk);
        #1 hold_busy = 1'b0;
        wait_drain();
        check("overflow[1] sticky", 32'(overflow[1]), 32'd1);

        // Reset between the two bytes of a sample.
        send_byte(8'h77);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state();
        fin_q0.push_back(16'h0201);
        fin_q1.push_back(16'h0102);
        send_byte(8'h01);
        send_byte(8'h02);
        check_strobe(0);

        // Timeout: only the LE instance discards the stale 0x55.
        fin_q1.push_back(16'h55AB);
        fin_q0.push_back(16'hCDAB);
        send_byte(8'h55);
        repeat (1001) @(posedge clk);
        send_byte(8'hAB);
        check_strobe(1);
        send_byte(8'hCD);
        check_strobe(0);

        repeat (20) @(posedge clk);
        check("pending fir_in[0]", 32'(fin_q0.size()), 32'd0);
        check("pending fir_in[1]", 32'(fin_q1.size()), 32'd0);
        check("pending tx[0]", 32'(txb_q0.size()), 32'd0);
        check("pending tx[1]", 32'(txb_q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
